// File: rtl/nonrecycle_counter_ctl_pkg.sv
// Shared state encoding and defaults for the non-recycling counter controller.
package nonrecycle_counter_ctl_pkg;
  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/nonrecycle_counter_ctl_updn_cnt_core.sv
// WIDTH-bit up/down count register with sync clear, sync load and async reset.
module updn_cnt_core #(
  parameter int             WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_V = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= RST_V;
    end else if (clr) begin
      q <= RST_V;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= q + 1'b1;
    end else if (dec) begin
      q <= q - 1'b1;
    end
  end

endmodule

// File: rtl/nonrecycle_counter_ctl.sv
// Non-recycling up/down counter with IDLE/RUN/HOLD control, done and terminal-count pulse.
module nonrecycle_counter_ctl
  import nonrecycle_counter_ctl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             sclr,
  input  logic             loadn,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             start,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse,
  output logic [1:0]       state_dbg
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  state_t           state, state_d;
  logic             tc_d;
  logic             core_clr, core_load, core_inc, core_dec;
  logic [WIDTH-1:0] core_load_val;
  logic [WIDTH-1:0] cnt_nxt;
  logic             term_cur, term_nxt;

  assign cnt_nxt  = up ? (count + 1'b1) : (count - 1'b1);
  assign term_cur = up ? (count >= limit) : (count == '0);
  assign term_nxt = up ? (cnt_nxt >= limit) : (cnt_nxt == '0);

  // Control priority per edge: sclr > loadn > start > en. No handshakes;
  // every input is sampled level-sensitively on each rising clk edge.
  always_comb begin
    state_d       = state;
    tc_d          = 1'b0;
    core_clr      = 1'b0;
    core_load     = 1'b0;
    core_load_val = cnt_in;
    core_inc      = 1'b0;
    core_dec      = 1'b0;
    if (sclr) begin
      core_clr = 1'b1;
      state_d  = ST_IDLE;
    end else if (!loadn) begin
      core_load = 1'b1;
      state_d   = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (term_cur) begin
            state_d = ST_HOLD;
            tc_d    = 1'b1;
          end else if (en) begin
            core_inc = up;
            core_dec = !up;
            // Terminal reached by this step: done rises with the terminal count.
            if (term_nxt) begin
              state_d = ST_HOLD;
              tc_d    = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (start) begin
            core_load     = 1'b1;
            core_load_val = up ? '0 : limit;
            state_d       = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_IDLE;
      tc_pulse <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      tc_pulse <= tc_d;
      busy     <= (state_d == ST_RUN);
      done     <= (state_d == ST_HOLD);
    end
  end

  assign state_dbg = state;

  updn_cnt_core #(
    .WIDTH (WIDTH),
    .RST_V (RST_V)
  ) u_core (
    .clk      (clk),
    .clrn     (clrn),
    .clr      (core_clr),
    .load     (core_load),
    .load_val (core_load_val),
    .inc      (core_inc),
    .dec      (core_dec),
    .q        (count)
  );

endmodule

// File: tb/tb_nonrecycle_counter_ctl.sv
// Self-checking bench for nonrecycle_counter_ctl (WIDTH=4, RST_VAL=0).
module tb_nonrecycle_counter_ctl;

  logic       clk = 1'b0;
  logic       clrn, sclr, loadn, up, start, en;
  logic [3:0] cnt_in, limit;
  logic [3:0] count;
  logic       busy, done, tc_pulse;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = idle, 1 = counting, 2 = held at terminal.
  int         m_mode;
  logic [3:0] m_count;
  logic       m_tc;

  nonrecycle_counter_ctl #(.WIDTH(4), .RST_VAL(0)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .sclr      (sclr),
    .loadn     (loadn),
    .cnt_in    (cnt_in),
    .limit     (limit),
    .up        (up),
    .start     (start),
    .en        (en),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .tc_pulse  (tc_pulse),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic bit at_terminal(input int c);
    return up ? (c >= int'(limit)) : (c == 0);
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_count = 4'd0;
    m_tc    = 1'b0;
  endtask

  // Applies one clock edge of the behavioural rules to the model.
  task automatic model_edge();
    int c;
    c    = int'(m_count);
    m_tc = 1'b0;
    if (sclr) begin
      c = 0; m_mode = 0;
    end else if (!loadn) begin
      c = int'(cnt_in); m_mode = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (at_terminal(c)) begin
        m_mode = 2; m_tc = 1'b1;
      end else if (en) begin
        c = up ? c + 1 : c - 1;
        if (at_terminal(c)) begin
          m_mode = 2; m_tc = 1'b1;
        end
      end
    end else begin
      if (start) begin
        c = up ? 0 : int'(limit);
        m_mode = 1;
      end
    end
    m_count = 4'(c);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet_inputs();
    sclr = 1'b0; loadn = 1'b1; start = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset();
    clrn = 1'b0; quiet_inputs(); up = 1'b1; limit = 4'd15; cnt_in = 4'd5;
    model_reset();
    @(negedge clk); clrn = 1'b1;
    loadn = 1'b0; tick(); loadn = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_setup: count=%0d busy=%b expected count=5 busy=1", count, busy);
    end
    #2; clrn = 1'b0; model_reset(); #1;
    checks++;
    if ({count, busy, done, tc_pulse} !== 7'd0) begin
      failures++;
      $display("FAIL reset_async: count=%0d busy=%b done=%b tc=%b expected all zero",
               count, busy, done, tc_pulse);
    end
    @(negedge clk); clrn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({count, busy, done, tc_pulse} !== 7'd0) begin
        failures++;
        $display("FAIL reset_release cyc%0d: count=%0d busy=%b done=%b tc=%b expected idle zero",
                 i, count, busy, done, tc_pulse);
      end
    end
  endtask

  task automatic test_up_run();
    int tc_seen = 0;
    limit = 4'd6; up = 1'b1;
    start = 1'b1; tick(); start = 1'b0; en = 1'b1;
    checks++;
    if (count !== 4'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL up_run_entry: count=%0d busy=%b expected count=0 busy=1", count, busy);
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (tc_pulse === 1'b1) tc_seen++;
      checks++;
      if (count !== ((i < 6) ? 4'(i) : 4'd6) || done !== (i >= 6)) begin
        failures++;
        $display("FAIL up_run cyc%0d: count=%0d done=%b expected count=%0d done=%b",
                 i, count, done, (i < 6) ? i : 6, (i >= 6));
      end
      if (i == 6) begin
        checks++;
        if (tc_pulse !== 1'b1) begin
          failures++;
          $display("FAIL up_run_tc: tc=%b expected 1 with count=6", tc_pulse);
        end
      end
    end
    checks++;
    if (tc_seen != 1) begin
      failures++;
      $display("FAIL up_run_tc_count: pulses=%0d expected 1", tc_seen);
    end
    en = 1'b0;
  endtask

  task automatic test_down_gaps();
    logic [3:0] exp_q[$];
    int         tc_seen = 0;
    int         en_seq[4] = '{1, 0, 1, 1};
    exp_q = '{4'd2, 4'd2, 4'd1, 4'd0};
    cnt_in = 4'd3; loadn = 1'b0; tick(); loadn = 1'b1;
    up = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] e;
      en = en_seq[i][0];
      tick();
      if (tc_pulse === 1'b1) tc_seen++;
      e = exp_q.pop_front();
      checks++;
      if (count !== e || done !== (i == 3) || count !== m_count) begin
        failures++;
        $display("FAIL down_gaps step%0d: count=%0d done=%b expected count=%0d done=%b",
                 i, count, done, e, (i == 3));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tc_pulse === 1'b1) tc_seen++;
    end
    checks++;
    if (tc_seen != 1 || count !== 4'd0 || done !== 1'b1) begin
      failures++;
      $display("FAIL down_gaps_hold: pulses=%0d count=%0d done=%b expected 1 0 1",
               tc_seen, count, done);
    end
  endtask

  task automatic test_load_beyond();
    int tc_seen = 0;
    cnt_in = 4'd9; loadn = 1'b0; tick(); loadn = 1'b1;
    up = 1'b1; limit = 4'd4; en = 1'b1; start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (count !== 4'd9 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL beyond_run: count=%0d busy=%b done=%b expected 9 1 0", count, busy, done);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tc_pulse === 1'b1) tc_seen++;
    end
    checks++;
    if (count !== 4'd9 || done !== 1'b1 || busy !== 1'b0 || tc_seen != 1) begin
      failures++;
      $display("FAIL beyond_hold: count=%0d done=%b busy=%b pulses=%0d expected 9 1 0 1",
               count, done, busy, tc_seen);
    end
    en = 1'b0;
  endtask

  task automatic test_restart();
    int tc_seen = 0;
    int cyc = 0;
    up = 1'b0; limit = 4'd5; start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (count !== 4'd5 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_entry: count=%0d done=%b busy=%b expected 5 0 1", count, done, busy);
    end
    en = 1'b1;
    while (done !== 1'b1 && cyc < 12) begin
      tick(); cyc++;
      if (tc_pulse === 1'b1) tc_seen++;
    end
    checks++;
    if (count !== 4'd0 || done !== 1'b1 || tc_seen != 1 || cyc != 5) begin
      failures++;
      $display("FAIL restart_down: count=%0d done=%b pulses=%0d cycles=%0d expected 0 1 1 5",
               count, done, tc_seen, cyc);
    end
    en = 1'b0;
  endtask

  task automatic test_priority();
    cnt_in = 4'd2; loadn = 1'b0; tick(); loadn = 1'b1;
    up = 1'b1; limit = 4'd10; start = 1'b1; tick(); start = 1'b0;
    sclr = 1'b1; loadn = 1'b0; en = 1'b1; cnt_in = 4'd7;
    tick();
    checks++;
    if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || tc_pulse !== 1'b0) begin
      failures++;
      $display("FAIL prio_sclr: count=%0d busy=%b done=%b tc=%b expected 0 0 0 0",
               count, busy, done, tc_pulse);
    end
    sclr = 1'b0; en = 1'b0; start = 1'b1;
    tick();
    checks++;
    if (count !== 4'd7 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL prio_load: count=%0d busy=%b done=%b expected 7 0 0", count, busy, done);
    end
    quiet_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      sclr   = ($urandom_range(0, 31) == 0);
      loadn  = ($urandom_range(0, 15) != 0);
      start  = ($urandom_range(0, 5) == 0);
      en     = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      if ($urandom_range(0, 19) == 0) limit = 4'($urandom_range(0, 15));
      cnt_in = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (count !== m_count || busy !== (m_mode == 1) || done !== (m_mode == 2) || tc_pulse !== m_tc) begin
        failures++;
        $display("FAIL random cyc%0d: count=%0d busy=%b done=%b tc=%b expected %0d %b %b %b",
                 i, count, busy, done, tc_pulse, m_count, (m_mode == 1), (m_mode == 2), m_tc);
      end
    end
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_up_run();
    test_down_gaps();
    test_load_beyond();
    test_restart();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
